// File: rtl/uart_cmd_rx.sv
// Host-command receiver for the logic probe: 8N1 byte receiver feeding a small
// command parser that owns the trigger/pre-trigger configuration and capture strobes.
module uart_cmd_rx #(
   parameter int CLK_HZ      = 12000000,
   parameter int BAUD        = 115200,
   parameter int AW          = 10,
   parameter int PRE_DEFAULT = 256,
   parameter int TIMEOUT_CYC = 120000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rx,
   output logic [7:0]  trig_mask,
   output logic [7:0]  trig_pattern,
   output logic [15:0] pre_samp,
   output logic        arm,
   output logic        abort,
   output logic        cmd_err,
   output logic        frame_err,
   output logic        busy
);

   localparam int BIT_CYC = (CLK_HZ + BAUD / 2) / BAUD;
   localparam int HALF    = BIT_CYC / 2;
   localparam int BW      = $clog2(BIT_CYC) + 1;
   localparam int TW      = $clog2(TIMEOUT_CYC + 1);

   localparam logic [BW-1:0] HALF_C   = BW'(HALF);
   localparam logic [BW-1:0] BIT_LAST = BW'(BIT_CYC);
   localparam logic [BW-1:0] CNT_ONE  = BW'(1);
   localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYC - 1);
   localparam logic [16:0]   PRE_LIM  = 17'(1) << AW;

   localparam logic [7:0] OP_MASK  = 8'h4D;
   localparam logic [7:0] OP_PAT   = 8'h50;
   localparam logic [7:0] OP_WIN   = 8'h57;
   localparam logic [7:0] OP_ARM   = 8'h41;
   localparam logic [7:0] OP_ABORT = 8'h58;

   typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_STOP, R_WAIT_HI} rx_state_t;
   typedef enum logic [1:0] {P_IDLE, P_ARG1, P_ARG2} p_state_t;

   rx_state_t       rstate;
   p_state_t        pstate;
   logic            rx_p0;
   logic            rxs;
   logic            rxs_prev;
   logic [BW-1:0]   bcnt;
   logic [2:0]      bit_idx;
   logic [7:0]      shift;
   logic [7:0]      opcode;
   logic [7:0]      arg_hi;
   logic [TW-1:0]   tcnt;
   logic            stop_tick;
   logic            byte_vld;
   logic            stop_bad;

   function automatic logic pre_in_range(input logic [15:0] v);
      return ({1'b0, v} < PRE_LIM);
   endfunction

   assign stop_tick = (rstate == R_STOP) && (bcnt == BIT_LAST);
   assign byte_vld  = stop_tick && rxs;
   assign stop_bad  = stop_tick && !rxs;
   assign busy      = (pstate != P_IDLE);

   // Stage p0/p1: two-flop synchronizer, then bit-timing receiver on rxs
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_p0     <= 1'b1;
         rxs       <= 1'b1;
         rxs_prev  <= 1'b1;
         rstate    <= R_IDLE;
         bcnt      <= '0;
         bit_idx   <= '0;
         frame_err <= 1'b0;
      end else begin
         rx_p0     <= rx;
         rxs       <= rx_p0;
         rxs_prev  <= rxs;
         frame_err <= 1'b0;
         case (rstate)
            R_IDLE: begin
               if (rxs_prev && !rxs) begin
                  rstate <= R_START;
                  bcnt   <= CNT_ONE;
               end
            end
            R_START: begin
               if (bcnt == HALF_C) begin
                  bcnt    <= CNT_ONE;
                  bit_idx <= '0;
                  rstate  <= rxs ? R_IDLE : R_DATA;
               end else begin
                  bcnt <= bcnt + CNT_ONE;
               end
            end
            R_DATA: begin
               if (bcnt == BIT_LAST) begin
                  bcnt <= CNT_ONE;
                  if (bit_idx == 3'd7) begin
                     rstate <= R_STOP;
                  end else begin
                     bit_idx <= bit_idx + 3'd1;
                  end
               end else begin
                  bcnt <= bcnt + CNT_ONE;
               end
            end
            R_STOP: begin
               if (bcnt == BIT_LAST) begin
                  if (rxs) begin
                     rstate <= R_IDLE;
                  end else begin
                     frame_err <= 1'b1;
                     rstate    <= R_WAIT_HI;
                  end
               end else begin
                  bcnt <= bcnt + CNT_ONE;
               end
            end
            R_WAIT_HI: begin
               if (rxs) rstate <= R_IDLE;
            end
            default: rstate <= R_IDLE;
         endcase
      end
   end

   // Data path: shift register and latched opcode/high argument carry no reset
   always_ff @(posedge clk) begin
      if (rstate == R_DATA && bcnt == BIT_LAST) shift <= {rxs, shift[7:1]};
      if (byte_vld && pstate == P_IDLE) opcode <= shift;
      if (byte_vld && pstate == P_ARG1) arg_hi <= shift;
   end

   // Stage p2: command parser, configuration registers and strobes
   always_ff @(posedge clk) begin
      if (rst) begin
         pstate       <= P_IDLE;
         tcnt         <= '0;
         trig_mask    <= 8'h00;
         trig_pattern <= 8'h00;
         pre_samp     <= 16'(PRE_DEFAULT);
         arm          <= 1'b0;
         abort        <= 1'b0;
         cmd_err      <= 1'b0;
      end else begin
         arm     <= 1'b0;
         abort   <= 1'b0;
         cmd_err <= 1'b0;
         if (byte_vld) begin
            tcnt <= '0;
            case (pstate)
               P_IDLE: begin
                  case (shift)
                     OP_MASK, OP_PAT, OP_WIN: pstate <= P_ARG1;
                     OP_ARM:                  arm    <= 1'b1;
                     OP_ABORT:                abort  <= 1'b1;
                     default:                 cmd_err <= 1'b1;
                  endcase
               end
               P_ARG1: begin
                  case (opcode)
                     OP_MASK: begin
                        trig_mask <= shift;
                        pstate    <= P_IDLE;
                     end
                     OP_PAT: begin
                        trig_pattern <= shift;
                        pstate       <= P_IDLE;
                     end
                     default: pstate <= P_ARG2;
                  endcase
               end
               P_ARG2: begin
                  // Window depth is committed only as a complete, in-range pair
                  if (pre_in_range({arg_hi, shift})) begin
                     pre_samp <= {arg_hi, shift};
                  end else begin
                     cmd_err <= 1'b1;
                  end
                  pstate <= P_IDLE;
               end
               default: pstate <= P_IDLE;
            endcase
         end else if (stop_bad && pstate != P_IDLE) begin
            cmd_err <= 1'b1;
            pstate  <= P_IDLE;
            tcnt    <= '0;
         end else if (pstate != P_IDLE) begin
            if (tcnt == TO_LAST) begin
               cmd_err <= 1'b1;
               pstate  <= P_IDLE;
               tcnt    <= '0;
            end else begin
               tcnt <= tcnt + TW'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_uart_cmd_rx.sv
// Bench for uart_cmd_rx: serial frames driven at bit level, a command-level model
// predicting every output on every cycle, plus literal spot values.
module tb_uart_cmd_rx;

   localparam int CLK_HZ      = 12000000;
   localparam int BAUD        = 115200;
   localparam int AW          = 10;
   localparam int PRE_DEFAULT = 256;
   localparam int TIMEOUT_CYC = 3000;
   localparam int BIT_CYC     = 104;
   localparam int HALF        = 52;
   // rx edge -> rxs (2) -> mid start (HALF) -> 8 data + stop bits -> registered output (1)
   localparam int OUT_LAT     = 2 + HALF + 9 * BIT_CYC + 1;

   typedef struct {
      int         t;
      logic [7:0] b;
      logic       ok;
   } arr_t;

   logic        clk;
   logic        rst;
   logic        rx;
   logic [7:0]  trig_mask;
   logic [7:0]  trig_pattern;
   logic [15:0] pre_samp;
   logic        arm;
   logic        abort;
   logic        cmd_err;
   logic        frame_err;
   logic        busy;

   uart_cmd_rx #(
      .CLK_HZ(CLK_HZ), .BAUD(BAUD), .AW(AW),
      .PRE_DEFAULT(PRE_DEFAULT), .TIMEOUT_CYC(TIMEOUT_CYC)
   ) dut (
      .clk(clk), .rst(rst), .rx(rx),
      .trig_mask(trig_mask), .trig_pattern(trig_pattern), .pre_samp(pre_samp),
      .arm(arm), .abort(abort), .cmd_err(cmd_err), .frame_err(frame_err), .busy(busy)
   );

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int arm_cnt = 0, abort_cnt = 0, cerr_cnt = 0, ferr_cnt = 0;

   arr_t       arr_q[$];
   logic [7:0] cmd_q[$];
   logic [7:0] m_mask, m_pat;
   logic [15:0] m_pre;
   logic       e_arm, e_abort, e_cerr, e_ferr;
   int         t_last;
   logic       rst_e;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got 0x%0h, want 0x%0h", name, cyc, act, exp);
      end
   endtask

   function automatic void model_byte(input arr_t a);
      logic [15:0] val;
      t_last = cyc;
      if (!a.ok) begin
         e_ferr = 1'b1;
         if (cmd_q.size() > 0) begin
            e_cerr = 1'b1;
            cmd_q.delete();
         end
      end else if (cmd_q.size() == 0) begin
         case (a.b)
            8'h4D, 8'h50, 8'h57: cmd_q.push_back(a.b);
            8'h41:               e_arm   = 1'b1;
            8'h58:               e_abort = 1'b1;
            default:             e_cerr  = 1'b1;
         endcase
      end else begin
         cmd_q.push_back(a.b);
         if (cmd_q[0] == 8'h4D) begin
            m_mask = a.b;
            cmd_q.delete();
         end else if (cmd_q[0] == 8'h50) begin
            m_pat = a.b;
            cmd_q.delete();
         end else if (cmd_q.size() == 3) begin
            val = {cmd_q[1], cmd_q[2]};
            if (val < (16'd1 << AW)) m_pre = val;
            else e_cerr = 1'b1;
            cmd_q.delete();
         end
      end
   endfunction

   // Model and per-cycle compare, evaluated mid-cycle
   initial begin
      arr_t a;
      logic got;
      m_mask = 8'h00; m_pat = 8'h00; m_pre = 16'(PRE_DEFAULT); t_last = 0;
      forever begin
         @(posedge clk);
         cyc++;
         rst_e = rst;
         @(negedge clk);
         e_arm = 1'b0; e_abort = 1'b0; e_cerr = 1'b0; e_ferr = 1'b0;
         if (rst_e) begin
            m_mask = 8'h00; m_pat = 8'h00; m_pre = 16'(PRE_DEFAULT);
            cmd_q.delete();
            arr_q.delete();
         end else begin
            got = 1'b0;
            if (arr_q.size() > 0 && arr_q[0].t == cyc) begin
               a = arr_q.pop_front();
               got = 1'b1;
               model_byte(a);
            end
            if (!got && cmd_q.size() > 0 && cyc == t_last + TIMEOUT_CYC) begin
               e_cerr = 1'b1;
               cmd_q.delete();
            end
         end
         check("trig_mask",    {8'h00, trig_mask},    {8'h00, m_mask});
         check("trig_pattern", {8'h00, trig_pattern}, {8'h00, m_pat});
         check("pre_samp",     pre_samp,              m_pre);
         check("arm",          {15'd0, arm},          {15'd0, e_arm});
         check("abort",        {15'd0, abort},        {15'd0, e_abort});
         check("cmd_err",      {15'd0, cmd_err},      {15'd0, e_cerr});
         check("frame_err",    {15'd0, frame_err},    {15'd0, e_ferr});
         check("busy",         {15'd0, busy},         {15'd0, (cmd_q.size() > 0)});
         if (arm === 1'b1)       arm_cnt++;
         if (abort === 1'b1)     abort_cnt++;
         if (cmd_err === 1'b1)   cerr_cnt++;
         if (frame_err === 1'b1) ferr_cnt++;
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop);
      arr_t a;
      a.t = cyc + OUT_LAT;
      a.b = b;
      a.ok = stop;
      arr_q.push_back(a);
      rx = 1'b0;
      tick(BIT_CYC);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         tick(BIT_CYC);
      end
      rx = stop;
      tick(BIT_CYC);
   endtask

   task automatic send(input logic [7:0] b);
      send_frame(b, 1'b1);
      tick(20);
   endtask

   initial begin
      logic [7:0] partial;
      rst = 1'b1;
      rx  = 1'b1;
      tick(5);
      rst = 1'b0;
      tick(10);
      check("reset_mask", {8'h00, trig_mask}, 16'h0000);
      check("reset_pre",  pre_samp,           16'd256);
      check("reset_busy", {15'd0, busy},      16'd0);

      send(8'h4D); send(8'hA5);
      check("mask_a5",     {8'h00, trig_mask},    16'h00A5);
      check("pat_zero",    {8'h00, trig_pattern}, 16'h0000);
      check("no_cmd_err",  16'(cerr_cnt),         16'd0);

      send(8'h57); send(8'h01);
      check("w_not_yet",   pre_samp,          16'd256);
      check("w_busy",      {15'd0, busy},     16'd1);
      send(8'h80);
      check("w_0180",      pre_samp,          16'h0180);
      send(8'h57); send(8'h04); send(8'h00);
      check("w_range_err", 16'(cerr_cnt),     16'd1);
      check("w_range_keep", pre_samp,         16'h0180);

      send(8'h41);
      check("arm_once",    16'(arm_cnt),      16'd1);
      send(8'h58);
      check("abort_once",  16'(abort_cnt),    16'd1);
      send(8'h50); send(8'h41);
      check("pat_41",      {8'h00, trig_pattern}, 16'h0041);
      check("arg_no_arm",  16'(arm_cnt),      16'd1);

      rx = 1'b0; tick(30); rx = 1'b1; tick(200);
      check("glitch_ferr", 16'(ferr_cnt),     16'd0);

      send(8'h50);
      send_frame(8'h55, 1'b0);
      tick(500);
      rx = 1'b1;
      tick(50);
      check("ferr_once",   16'(ferr_cnt),     16'd1);
      check("ferr_cerr",   16'(cerr_cnt),     16'd2);
      check("ferr_pat",    {8'h00, trig_pattern}, 16'h0041);
      send(8'h4D); send(8'h0F);
      check("mask_0f",     {8'h00, trig_mask}, 16'h000F);

      send(8'h4D);
      tick(TIMEOUT_CYC + 50);
      check("timeout_err", 16'(cerr_cnt),     16'd3);
      check("timeout_busy", {15'd0, busy},    16'd0);
      send(8'h3C);
      check("unknown_err", 16'(cerr_cnt),     16'd4);
      check("unknown_mask", {8'h00, trig_mask}, 16'h000F);

      send(8'h57);
      partial = 8'h01;
      rx = 1'b0;
      tick(BIT_CYC);
      for (int i = 0; i < 4; i++) begin
         rx = partial[i];
         tick(BIT_CYC);
      end
      rx = partial[4];
      tick(50);
      rst = 1'b1;
      rx  = 1'b1;
      tick(3);
      rst = 1'b0;
      tick(20);
      check("rst_busy",    {15'd0, busy},     16'd0);
      check("rst_pre",     pre_samp,          16'd256);
      send(8'h41);
      check("arm_after_rst", 16'(arm_cnt),    16'd2);

      tick(10);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
